// File: rtl/rxstat_pkg.sv
// Shared constants and the strobe bundle type for the RX statistics vector decoder.
package rxstat_pkg;

    localparam int MAX_FRAME  = 1518;
    localparam int LEN_W      = 14;
    localparam int VLAN_EXTRA = 4;
    localparam int NUM_BINS   = 6;

    localparam int BIN_64   = 0;
    localparam int BIN_127  = 1;
    localparam int BIN_255  = 2;
    localparam int BIN_511  = 3;
    localparam int BIN_1023 = 4;
    localparam int BIN_MAX  = 5;

    localparam int LEN_64   = 64;
    localparam int LEN_127  = 127;
    localparam int LEN_255  = 255;
    localparam int LEN_511  = 511;
    localparam int LEN_1023 = 1023;

    typedef struct packed {
        logic                pkt;
        logic                fcs;
        logic                bca;
        logic                mca;
        logic                xcf;
        logic                und;
        logic                ovr;
        logic                frg;
        logic                jbr;
        logic                drp;
        logic                vlan;
        logic [NUM_BINS-1:0] bin;
        logic                byt;
    } strobe_t;

endpackage

// File: rtl/rxstat_vecdec_if.sv
// Status-vector input and increment-strobe output bundle of rxstat_vecdec.
interface rxstat_vecdec_if
    import rxstat_pkg::*;
    ();

    // vec_valid is a one-cycle end-of-frame strobe qualifying all vec_* fields;
    // there is no ready: a vector is accepted on every cycle it is presented.
    logic                stat_en;
    logic                vec_valid;
    logic [LEN_W-1:0]    vec_len;
    logic                vec_crc_err;
    logic                vec_bcast;
    logic                vec_mcast;
    logic                vec_pause;
    logic                vec_vlan;
    logic                vec_trunc;

    logic                inc_pkt, inc_fcs, inc_bca, inc_mca, inc_xcf;
    logic                inc_und, inc_ovr, inc_frg, inc_jbr;
    logic                inc_drp;
    logic                inc_vlan;
    logic [NUM_BINS-1:0] inc_bin;
    logic                inc_byt;
    logic [LEN_W-1:0]    byt_amt;

    modport master (
        output stat_en, vec_valid, vec_len, vec_crc_err, vec_bcast, vec_mcast,
               vec_pause, vec_vlan, vec_trunc,
        input  inc_pkt, inc_fcs, inc_bca, inc_mca, inc_xcf, inc_und, inc_ovr,
               inc_frg, inc_jbr, inc_drp, inc_vlan, inc_bin, inc_byt, byt_amt
    );

    modport slave (
        input  stat_en, vec_valid, vec_len, vec_crc_err, vec_bcast, vec_mcast,
               vec_pause, vec_vlan, vec_trunc,
        output inc_pkt, inc_fcs, inc_bca, inc_mca, inc_xcf, inc_und, inc_ovr,
               inc_frg, inc_jbr, inc_drp, inc_vlan, inc_bin, inc_byt, byt_amt
    );

endinterface

// File: rtl/rxstat_lencls.sv
// Combinational frame-length classifier: size bin one-hot plus short/long flags.
// RXSTAT_VLAN_EN raises the length limit by VLAN_EXTRA for tagged frames.
module rxstat_lencls
    import rxstat_pkg::*;
(
    input  logic [LEN_W-1:0]    len,
    input  logic                vlan,
    output logic [NUM_BINS-1:0] bin,
    output logic                is_short,
    output logic                is_long
);

    logic [LEN_W-1:0] lmax;

    always_comb begin
        lmax = LEN_W'(MAX_FRAME);
`ifdef RXSTAT_VLAN_EN
        if (vlan) begin
            lmax = LEN_W'(MAX_FRAME + VLAN_EXTRA);
        end
`endif
        bin = '0;
        // First match wins, so each bin's lower bound is implicit.
        if (len <= LEN_W'(LEN_64)) begin
            bin[BIN_64] = 1'b1;
        end else if (len <= LEN_W'(LEN_127)) begin
            bin[BIN_127] = 1'b1;
        end else if (len <= LEN_W'(LEN_255)) begin
            bin[BIN_255] = 1'b1;
        end else if (len <= LEN_W'(LEN_511)) begin
            bin[BIN_511] = 1'b1;
        end else if (len <= LEN_W'(LEN_1023)) begin
            bin[BIN_1023] = 1'b1;
        end else if (len <= lmax) begin
            bin[BIN_MAX] = 1'b1;
        end
    end

    assign is_short = (len < LEN_W'(LEN_64));
    assign is_long  = (len > lmax);

`ifndef RXSTAT_VLAN_EN
    logic vlan_unused;
    assign vlan_unused = vlan;
`endif

endmodule

// File: rtl/rxstat_vecdec.sv
// RX status vector decoder: two-stage pipeline turning end-of-frame vectors into
// counter increment strobes. RXSTAT_VLAN_EN enables VLAN-aware limits and inc_vlan.
module rxstat_vecdec
    import rxstat_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    rxstat_vecdec_if.slave bus
);

    logic [NUM_BINS-1:0] cls_bin;
    logic                cls_short;
    logic                cls_long;

    rxstat_lencls u_lencls (
        .len      (bus.vec_len),
        .vlan     (bus.vec_vlan),
        .bin      (cls_bin),
        .is_short (cls_short),
        .is_long  (cls_long)
    );

    logic                s1_valid;
    logic [LEN_W-1:0]    s1_len;
    logic                s1_crc, s1_bcast, s1_mcast, s1_pause, s1_trunc;
    logic [NUM_BINS-1:0] s1_bin;
    logic                s1_short, s1_long;
`ifdef RXSTAT_VLAN_EN
    logic                s1_vlan;
`endif

    // Vectors seen with stat_en low are consumed here and never reach stage 2.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= bus.vec_valid & bus.stat_en;
        end
    end

    always_ff @(posedge clk) begin
        if (bus.vec_valid) begin
            s1_len   <= bus.vec_len;
            s1_crc   <= bus.vec_crc_err;
            s1_bcast <= bus.vec_bcast;
            s1_mcast <= bus.vec_mcast;
            s1_pause <= bus.vec_pause;
            s1_trunc <= bus.vec_trunc;
            s1_bin   <= cls_bin;
            s1_short <= cls_short;
            s1_long  <= cls_long;
`ifdef RXSTAT_VLAN_EN
            s1_vlan  <= bus.vec_vlan;
`endif
        end
    end

    strobe_t          nxt, st;
    logic [LEN_W-1:0] nxt_amt, amt;
    logic             good;

    assign good = ~s1_crc;

    always_comb begin
        nxt     = '0;
        nxt_amt = '0;
        if (s1_valid) begin
            if (s1_trunc) begin
                nxt.drp = 1'b1;
            end else begin
                nxt.pkt = 1'b1;
                nxt.byt = 1'b1;
                nxt_amt = s1_len;
                nxt.bin = s1_bin;
                nxt.und = good & s1_short;
                nxt.frg = ~good & s1_short;
                nxt.ovr = good & s1_long;
                nxt.jbr = ~good & s1_long;
                nxt.fcs = ~good & ~s1_short & ~s1_long;
                nxt.bca = good & s1_bcast;
                nxt.mca = good & s1_mcast & ~s1_bcast;
                nxt.xcf = good & s1_pause;
`ifdef RXSTAT_VLAN_EN
                nxt.vlan = good & s1_vlan;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st  <= '0;
            amt <= '0;
        end else begin
            st  <= nxt;
            amt <= nxt_amt;
        end
    end

    assign bus.inc_pkt  = st.pkt;
    assign bus.inc_fcs  = st.fcs;
    assign bus.inc_bca  = st.bca;
    assign bus.inc_mca  = st.mca;
    assign bus.inc_xcf  = st.xcf;
    assign bus.inc_und  = st.und;
    assign bus.inc_ovr  = st.ovr;
    assign bus.inc_frg  = st.frg;
    assign bus.inc_jbr  = st.jbr;
    assign bus.inc_drp  = st.drp;
    assign bus.inc_vlan = st.vlan;
    assign bus.inc_bin  = st.bin;
    assign bus.inc_byt  = st.byt;
    assign bus.byt_amt  = amt;

endmodule

// File: tb/tb_rxstat_vecdec.sv
// Self-checking bench for rxstat_vecdec: directed and random vectors against a
// rule-level reference model; honours RXSTAT_VLAN_EN like the design.
module tb_rxstat_vecdec;
    import rxstat_pkg::*;

    typedef struct {
        bit valid;
        bit en;
        int len;
        bit crc;
        bit bcast;
        bit mcast;
        bit pause;
        bit vlan;
        bit trunc;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    rxstat_vecdec_if bus ();

    rxstat_vecdec dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    // Expected output word for one input vector, straight from the frame rules.
    function automatic logic [31:0] model(vec_t v);
        int lmax;
        bit good;
        int ub[6];
        logic [5:0] bin;
        bit pkt, fcs, bca, mca, xcf, und, ovr, frg, jbr, drp, vl, byt;
        logic [13:0] amt;
        bin = '0;
        {pkt, fcs, bca, mca, xcf, und, ovr, frg, jbr, drp, vl, byt} = '0;
        amt = '0;
        if (v.valid && v.en) begin
            good = !v.crc;
            lmax = 1518;
`ifdef RXSTAT_VLAN_EN
            if (v.vlan) lmax = 1518 + 4;
            vl = good && v.vlan && !v.trunc;
`endif
            if (v.trunc) begin
                drp = 1'b1;
            end else begin
                pkt = 1'b1;
                byt = 1'b1;
                amt = 14'(v.len);
                ub = '{64, 127, 255, 511, 1023, lmax};
                for (int i = 0; i < 6; i++) begin
                    if (v.len <= ub[i]) begin
                        bin[i] = 1'b1;
                        break;
                    end
                end
                und = good && v.len < 64;
                frg = !good && v.len < 64;
                ovr = good && v.len > lmax;
                jbr = !good && v.len > lmax;
                fcs = !good && v.len >= 64 && v.len <= lmax;
                bca = good && v.bcast;
                mca = good && v.mcast && !v.bcast;
                xcf = good && v.pause;
            end
        end
        return {pkt, fcs, bca, mca, xcf, und, ovr, frg, jbr, drp, vl, bin, byt, amt};
    endfunction

    function automatic logic [31:0] dut_word();
        return {bus.inc_pkt, bus.inc_fcs, bus.inc_bca, bus.inc_mca, bus.inc_xcf,
                bus.inc_und, bus.inc_ovr, bus.inc_frg, bus.inc_jbr, bus.inc_drp,
                bus.inc_vlan, bus.inc_bin, bus.inc_byt, bus.byt_amt};
    endfunction

    function automatic vec_t mk(bit en, int len, bit crc, bit bcast, bit mcast,
                                bit pause, bit vlan, bit trunc);
        vec_t v;
        v.valid = 1'b1; v.en = en; v.len = len; v.crc = crc; v.bcast = bcast;
        v.mcast = mcast; v.pause = pause; v.vlan = vlan; v.trunc = trunc;
        return v;
    endfunction

    function automatic vec_t idle();
        vec_t v;
        v = mk(1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        v.valid = 1'b0;
        return v;
    endfunction

    // Drive one vector for one clock and queue what must appear two edges later.
    task automatic drive_edge(input vec_t v, input bit rst);
        reset           = rst;
        bus.stat_en     = v.en;
        bus.vec_valid   = v.valid;
        bus.vec_len     = 14'(v.len);
        bus.vec_crc_err = v.crc;
        bus.vec_bcast   = v.bcast;
        bus.vec_mcast   = v.mcast;
        bus.vec_pause   = v.pause;
        bus.vec_vlan    = v.vlan;
        bus.vec_trunc   = v.trunc;
        @(posedge clk);
        #1;
        if (rst) begin
            exp_q.delete();
            exp_q.push_back('0);
            exp_q.push_back('0);
        end else begin
            exp_q.push_back(model(v));
        end
    endtask

    task automatic test_reset();
        logic [31:0] exp;
        for (int i = 0; i < 3; i++) begin
            drive_edge(idle(), 1'b1);
            exp = exp_q.pop_front();
            checks++;
            if (dut_word() !== exp) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d got %h expected %h", i, dut_word(), exp);
            end
        end
        checks++;
        if (bus.byt_amt !== 14'd0) begin
            errors++;
            $display("FAIL reset_byt_amt got %0d expected 0", bus.byt_amt);
        end
        for (int i = 0; i < 2; i++) begin
            drive_edge(idle(), 1'b0);
            exp = exp_q.pop_front();
            checks++;
            if (dut_word() !== exp) begin
                errors++;
                $display("FAIL post_reset_idle cycle %0d got %h expected %h", i, dut_word(), exp);
            end
        end
    endtask

    task automatic test_directed();
        vec_t tbl[$];
        logic [31:0] exp;
        tbl.push_back(mk(1, 64, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 63, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1519, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1519, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 1523, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 1522, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 1522, 1, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 1518, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1518, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 65, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 127, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(1, 128, 1, 1, 1, 1, 1, 0));
        tbl.push_back(mk(1, 255, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 256, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 511, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 512, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1023, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1024, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 16383, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 16383, 0, 1, 0, 1, 1, 0));
        tbl.push_back(idle());
        tbl.push_back(idle());
        foreach (tbl[i]) begin
            drive_edge(tbl[i], 1'b0);
            exp = exp_q.pop_front();
            checks++;
            if (dut_word() !== exp) begin
                errors++;
                $display("FAIL directed step %0d got %h expected %h", i, dut_word(), exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        vec_t tbl[$];
        logic [31:0] exp;
        tbl.push_back(mk(1, 100, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 300, 0, 1, 1, 0, 0, 1));
        tbl.push_back(mk(1, 1000, 0, 0, 1, 0, 0, 0));
        tbl.push_back(idle());
        tbl.push_back(idle());
        foreach (tbl[i]) begin
            drive_edge(tbl[i], 1'b0);
            exp = exp_q.pop_front();
            checks++;
            if (dut_word() !== exp) begin
                errors++;
                $display("FAIL back_to_back step %0d got %h expected %h", i, dut_word(), exp);
            end
        end
    endtask

    task automatic test_stat_en();
        vec_t tbl[$];
        logic [31:0] exp;
        tbl.push_back(mk(0, 200, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 300, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 400, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 500, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 40, 0, 0, 0, 1, 0, 0));
        tbl.push_back(idle());
        tbl.push_back(idle());
        foreach (tbl[i]) begin
            drive_edge(tbl[i], 1'b0);
            exp = exp_q.pop_front();
            checks++;
            if (dut_word() !== exp) begin
                errors++;
                $display("FAIL stat_en step %0d got %h expected %h", i, dut_word(), exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] exp;
        for (int i = 0; i < 6; i++) begin
            case (i)
                0:       drive_edge(mk(1, 700, 0, 1, 0, 0, 0, 0), 1'b0);
                1:       drive_edge(mk(1, 90, 0, 0, 1, 0, 0, 0), 1'b1);
                default: drive_edge(idle(), 1'b0);
            endcase
            exp = exp_q.pop_front();
            checks++;
            if (dut_word() !== exp) begin
                errors++;
                $display("FAIL reset_mid step %0d got %h expected %h", i, dut_word(), exp);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] exp;
        vec_t v;
        int edges[5];
        edges = '{0, 63, 64, 1518, 1522};
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0:       v.len = $urandom_range(0, 130);
                1:       v.len = $urandom_range(1500, 1530);
                2:       v.len = $urandom_range(0, 16383);
                default: v.len = edges[$urandom_range(0, 4)] + $urandom_range(0, 1);
            endcase
            v.valid = ($urandom_range(0, 9) < 8);
            v.en    = ($urandom_range(0, 9) < 9);
            v.crc   = ($urandom_range(0, 9) < 3);
            v.bcast = $urandom_range(0, 1);
            v.mcast = $urandom_range(0, 1);
            v.pause = ($urandom_range(0, 3) == 0);
            v.vlan  = $urandom_range(0, 1);
            v.trunc = ($urandom_range(0, 9) == 0);
            drive_edge(v, 1'b0);
            exp = exp_q.pop_front();
            checks++;
            if (dut_word() !== exp) begin
                errors++;
                $display("FAIL random step %0d got %h expected %h", i, dut_word(), exp);
            end
        end
        for (int i = 0; i < 2; i++) begin
            drive_edge(idle(), 1'b0);
            exp = exp_q.pop_front();
            checks++;
            if (dut_word() !== exp) begin
                errors++;
                $display("FAIL random_drain step %0d got %h expected %h", i, dut_word(), exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_stat_en();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
